// File: rtl/urv_typedef.sv
// Shared AHB type package for the peripheral-bus slice (mem2ahb, ahb2apb).
//   htrans_type_t  : AHB transfer type
//   hsize_type_t   : AHB transfer size
//   hburst_type_t  : AHB burst type
//   ahb_strb()     : byte-lane strobes for a 32-bit lane from hsize/addr[1:0]
package urv_typedef;

  typedef enum logic [1:0] {
    HTRANS_IDLE   = 2'b00,
    HTRANS_BUSY   = 2'b01,
    HTRANS_NONSEQ = 2'b10,
    HTRANS_SEQ    = 2'b11
  } htrans_type_t;

  typedef enum logic [2:0] {
    HSIZE_BYTE  = 3'd0,
    HSIZE_HALF  = 3'd1,
    HSIZE_WORD  = 3'd2,
    HSIZE_DWORD = 3'd3,
    HSIZE_4W    = 3'd4,
    HSIZE_8W    = 3'd5,
    HSIZE_16W   = 3'd6,
    HSIZE_32W   = 3'd7
  } hsize_type_t;

  typedef enum logic [2:0] {
    HBURST_SINGLE = 3'd0,
    HBURST_INCR   = 3'd1,
    HBURST_WRAP4  = 3'd2,
    HBURST_INCR4  = 3'd3,
    HBURST_WRAP8  = 3'd4,
    HBURST_INCR8  = 3'd5,
    HBURST_WRAP16 = 3'd6,
    HBURST_INCR16 = 3'd7
  } hburst_type_t;

  // Sizes wider than a word have no lane mapping on a 32-bit bus -> no strobes.
  function automatic logic [3:0] ahb_strb(input hsize_type_t hsize, input logic [1:0] addr);
    case (hsize)
      HSIZE_BYTE: return 4'b0001 << addr;
      HSIZE_HALF: return 4'b0011 << addr;
      HSIZE_WORD: return 4'b1111;
      default:    return 4'b0000;
    endcase
  endfunction

endpackage

// File: rtl/ahb2apb.sv
// AHB-Lite slave -> APB3 master bridge (one APB SETUP/ACCESS pair per NONSEQ/SEQ).
// Errors (pslverr, ACCESS timeout, illegal size/alignment) give the two-cycle
// AHB ERROR response. BUSY/IDLE are zero-wait OKAY.
// Optional macro APB_PSTRB_EN adds APB4 pstrb/pprot outputs.
// Ports:
//   clk, rst                 clock, synchronous active-high reset
//   hsel/htrans/haddr/hsize  AHB address phase (sampled when hready)
//   hwrite/hwdata/hready     AHB control/data
//   hreadyout/hresp/hrdata   AHB response
//   psel/penable/paddr       APB request
//   pwrite/pwdata            APB write path
//   prdata/pready/pslverr    APB completion
//   pstrb/pprot              APB4 extras (APB_PSTRB_EN only)
// Parameters: N_AW address width, N_DW data width (32 only),
//   TIMEOUT_W ACCESS timeout counter width (0 = no timeout).
module ahb2apb
  import urv_typedef::*;
#(
  parameter int N_AW      = 32,
  parameter int N_DW      = 32,
  parameter int TIMEOUT_W = 8
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            hsel,
  input  logic [1:0]      htrans,
  input  logic [N_AW-1:0] haddr,
  input  logic [2:0]      hsize,
  input  logic            hwrite,
  input  logic [N_DW-1:0] hwdata,
  input  logic            hready,
  output logic            hreadyout,
  output logic            hresp,
  output logic [N_DW-1:0] hrdata,
  output logic            psel,
  output logic            penable,
  output logic [N_AW-1:0] paddr,
  output logic            pwrite,
  output logic [N_DW-1:0] pwdata,
  input  logic [N_DW-1:0] prdata,
  input  logic            pready,
  input  logic            pslverr
`ifdef APB_PSTRB_EN
  ,
  output logic [3:0]      pstrb,
  output logic [2:0]      pprot
`endif
);

  typedef logic [2:0] apb_state_t;
  localparam apb_state_t ST_IDLE    = 3'd0;
  localparam apb_state_t ST_WAIT_WD = 3'd1;
  localparam apb_state_t ST_SETUP   = 3'd2;
  localparam apb_state_t ST_ACCESS  = 3'd3;
  localparam apb_state_t ST_ERR1    = 3'd4;
  localparam apb_state_t ST_ERR2    = 3'd5;

  typedef struct packed {
    logic [N_AW-1:0] addr;
    logic            write;
  } ahb_req_t;

  apb_state_t  state, state_nxt;
  ahb_req_t    req_q;
  hsize_type_t hsize_e;
  logic        acc, legal, to_hit, rd_done;
  logic [N_DW-1:0] hrdata_q;

  // Only htrans[1] distinguishes transfers from IDLE/BUSY.
  logic unused_htrans0;
  assign unused_htrans0 = htrans[0];

  assign hsize_e = hsize_type_t'(hsize);

  // hreadyout is only high in IDLE, ERR2 and an OKAY ACCESS completion, so
  // these are exactly the cycles where a new address phase can be taken.
  assign acc = hsel & hready & htrans[1] & hreadyout;

  always_comb begin
    legal = 1'b0;
    case (hsize_e)
      HSIZE_BYTE: legal = 1'b1;
      HSIZE_HALF: legal = ~haddr[0];
      HSIZE_WORD: legal = (haddr[1:0] == 2'b00);
      default:    legal = 1'b0;
    endcase
  end

  // Timeout: counts stalled ACCESS cycles; fires on the stall cycle that
  // would bring the count to all-ones.
  generate
    if (TIMEOUT_W > 0) begin : g_to
      logic [TIMEOUT_W-1:0] to_cnt, to_inc;
      assign to_inc = to_cnt + TIMEOUT_W'(1);
      assign to_hit = (state == ST_ACCESS) & ~pready & (&to_inc);
      always_ff @(posedge clk) begin
        if (rst)                             to_cnt <= '0;
        else if (state == ST_SETUP)          to_cnt <= '0;
        else if (state == ST_ACCESS & ~pready) to_cnt <= to_inc;
      end
    end else begin : g_no_to
      assign to_hit = 1'b0;
    end
  endgenerate

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:    state_nxt = ST_IDLE;
      ST_WAIT_WD: state_nxt = ST_SETUP;
      ST_SETUP:   state_nxt = ST_ACCESS;
      ST_ACCESS: begin
        if (pready)      state_nxt = pslverr ? ST_ERR1 : ST_IDLE;
        else if (to_hit) state_nxt = ST_ERR1;
      end
      ST_ERR1:    state_nxt = ST_ERR2;
      ST_ERR2:    state_nxt = ST_IDLE;
      default:    state_nxt = ST_IDLE;
    endcase
    // A new address phase overrides the idle return (back-to-back path).
    if (acc) state_nxt = !legal ? ST_ERR1 : (hwrite ? ST_WAIT_WD : ST_SETUP);
  end

  always_comb begin
    case (state)
      ST_IDLE, ST_ERR2: hreadyout = 1'b1;
      ST_ACCESS:        hreadyout = pready & ~pslverr;
      default:          hreadyout = 1'b0;
    endcase
  end

  assign hresp   = (state == ST_ERR1) | (state == ST_ERR2);
  assign psel    = (state == ST_SETUP) | (state == ST_ACCESS);
  assign penable = (state == ST_ACCESS);
  assign paddr   = req_q.addr;
  assign pwrite  = req_q.write;

  // Read data is forwarded in the completing ACCESS cycle and held after.
  assign rd_done = (state == ST_ACCESS) & pready & ~pslverr & ~req_q.write;
  assign hrdata  = rd_done ? prdata : hrdata_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= ST_IDLE;
      req_q    <= '0;
      pwdata   <= '0;
      hrdata_q <= '0;
    end else begin
      state <= state_nxt;
      if (acc) begin
        req_q.addr  <= haddr;
        req_q.write <= hwrite;
      end
      // Write data arrives one cycle after the address phase.
      if (state == ST_WAIT_WD) pwdata <= hwdata;
      if (rd_done)             hrdata_q <= prdata;
    end
  end

`ifdef APB_PSTRB_EN
  assign pprot = 3'b010;
  always_ff @(posedge clk) begin
    if (rst)      pstrb <= 4'b0000;
    else if (acc) pstrb <= hwrite ? ahb_strb(hsize_e, haddr[1:0]) : 4'b0000;
  end
`endif

endmodule

// File: tb/tb_ahb2apb.sv
module tb_ahb2apb;

  localparam int TW     = 4;
  localparam int TO_CYC = (1 << TW) - 1;

  logic        clk = 1'b0;
  logic        rst;
  logic        hsel, hwrite, hready;
  logic [1:0]  htrans;
  logic [31:0] haddr, hwdata, hrdata, paddr, pwdata, prdata;
  logic [2:0]  hsize;
  logic        hreadyout, hresp, psel, penable, pwrite, pready, pslverr;
`ifdef APB_PSTRB_EN
  logic [3:0]  pstrb;
  logic [2:0]  pprot;
`endif

  ahb2apb #(.N_AW(32), .N_DW(32), .TIMEOUT_W(TW)) dut (
    .clk(clk), .rst(rst), .hsel(hsel), .htrans(htrans), .haddr(haddr),
    .hsize(hsize), .hwrite(hwrite), .hwdata(hwdata), .hready(hready),
    .hreadyout(hreadyout), .hresp(hresp), .hrdata(hrdata),
    .psel(psel), .penable(penable), .paddr(paddr), .pwrite(pwrite),
    .pwdata(pwdata), .prdata(prdata), .pready(pready), .pslverr(pslverr)
`ifdef APB_PSTRB_EN
    , .pstrb(pstrb), .pprot(pprot)
`endif
  );

  always #5 clk = ~clk;

  int          n_cmp = 0, n_err = 0;
  int          wait_n = 0, acc_cnt = 0;
  bit          err_n = 1'b0;
  logic [31:0] rdata_n = '0;
  logic [31:0] last_rd = '0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // One clock: at the falling edge the APB slave model answers the current
  // cycle, then outputs settle and the caller observes / drives AHB.
  task automatic cyc();
    @(negedge clk);
    if (psel && penable) begin
      pready  = (acc_cnt >= wait_n);
      pslverr = pready && err_n;
      prdata  = pready ? rdata_n : $urandom;
      acc_cnt++;
    end else begin
      pready  = 1'($urandom_range(0, 1));
      pslverr = 1'($urandom_range(0, 1));
      prdata  = $urandom;
      acc_cnt = 0;
    end
    #1;
  endtask

  task automatic idle(input int n);
    hsel = 1'b0; htrans = 2'b00;
    repeat (n) cyc();
  endtask

  // Issues one transfer in the current cycle and follows it to completion.
  // Expectations come from the transfer-level rules: legality, APB wait
  // count, slave error and the timeout limit.
  task automatic do_xfer(input logic [31:0] addr, input logic [2:0] size, input bit wr,
                         input logic [31:0] wdata, input int wn, input bit er,
                         input logic [31:0] rd);
    bit          legal, tmo, bad, done;
    int          n_acc, lat, n, n_set, n_ac, unstable;
    logic [31:0] exp_rd;
    logic [3:0]  exp_strb;
    logic        prev_resp, fin_resp;
    legal = 1'b0;
    if (size <= 3'd2) legal = ((addr % (32'd1 << size)) == 0);
    tmo      = legal && (wn >= TO_CYC);
    bad      = !legal || tmo || er;
    n_acc    = !legal ? 0 : (tmo ? TO_CYC : wn + 1);
    lat      = !legal ? 2 : (wr ? 1 : 0) + 1 + n_acc + (bad ? 2 : 0);
    exp_rd   = (legal && !bad && !wr) ? rd : last_rd;
    exp_strb = '0;
    if (legal && wr) exp_strb = 4'(((1 << (1 << int'(size))) - 1) << addr[1:0]);

    chk("ready_at_addr", hreadyout, 1);
    wait_n = wn; err_n = er; rdata_n = rd;
    hsel = 1'b1; hready = 1'b1; htrans = 2'b10;
    haddr = addr; hsize = size; hwrite = wr; hwdata = $urandom;
    n = 0; n_set = 0; n_ac = 0; unstable = 0; done = 1'b0;
    prev_resp = 1'b0; fin_resp = 1'b0;
    while (!done && n < 64) begin
      cyc();
      n++;
      if (n == 1) begin
        htrans = 2'b00; hsel = 1'($urandom_range(0, 1));
        haddr = $urandom; hwrite = 1'($urandom_range(0, 1)); hwdata = wdata;
      end else begin
        hwdata = $urandom;
      end
      if (psel) begin
        if (paddr !== addr || pwrite !== wr || (wr && penable && pwdata !== wdata)) unstable++;
        if (!penable) begin
          n_set++;
`ifdef APB_PSTRB_EN
          chk("pstrb", pstrb, exp_strb);
          chk("pprot", pprot, 3'b010);
`endif
        end else n_ac++;
      end
      if (hreadyout) begin done = 1'b1; fin_resp = hresp; end
      else prev_resp = hresp;
    end
    chk("xfer_done", done, 1);
    if (!done) return;
    chk("latency", n, lat);
    chk("hresp_final", fin_resp, bad);
    chk("hresp_prev", prev_resp, bad);
    chk("n_setup", n_set, legal ? 1 : 0);
    chk("n_access", n_ac, n_acc);
    chk("apb_stable", unstable, 0);
    chk("hrdata", hrdata, exp_rd);
    last_rd = exp_rd;
  endtask

  task automatic chk_reset_vals();
    chk("rst_hreadyout", hreadyout, 1);
    chk("rst_hresp", hresp, 0);
    chk("rst_psel", psel, 0);
    chk("rst_penable", penable, 0);
    chk("rst_paddr", paddr, 0);
    chk("rst_pwdata", pwdata, 0);
    chk("rst_hrdata", hrdata, 0);
`ifdef APB_PSTRB_EN
    chk("rst_pstrb", pstrb, 0);
`endif
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    logic [31:0] a;
    logic [2:0]  s;
    int          wn;
    rst = 1'b1; hsel = 1'b0; htrans = 2'b00; haddr = '0; hsize = 3'd2;
    hwrite = 1'b0; hwdata = '0; hready = 1'b1;
    pready = 1'b0; pslverr = 1'b0; prdata = '0;
    repeat (3) cyc();
    chk_reset_vals();
    rst = 1'b0;
    cyc();

    // Directed cases
    do_xfer(32'h1000_0004, 3'd2, 1'b0, 32'h0, 0, 1'b0, 32'hDEAD_BEEF);
    idle(1);
    do_xfer(32'h1000_0003, 3'd0, 1'b1, 32'h5500_0000, 3, 1'b0, 32'h0);
    idle(1);
    do_xfer(32'h1000_0008, 3'd2, 1'b0, 32'h0, 0, 1'b1, 32'h1234_5678);
    idle(1);
    do_xfer(32'h1000_0002, 3'd2, 1'b0, 32'h0, 0, 1'b0, 32'h1111_1111);
    idle(1);
    do_xfer(32'h1000_0010, 3'd2, 1'b0, 32'h0, 100, 1'b0, 32'h2222_2222);
    do_xfer(32'h0000_0000, 3'd2, 1'b0, 32'h0, 0, 1'b0, 32'hCAFE_F00D);

    // Back-to-back reads, then a BUSY cycle, then another read
    do_xfer(32'h2000_0000, 3'd2, 1'b0, 32'h0, 1, 1'b0, 32'hA5A5_0001);
    do_xfer(32'h2000_0004, 3'd1, 1'b0, 32'h0, 0, 1'b0, 32'hA5A5_0002);
    hsel = 1'b1; htrans = 2'b01; haddr = 32'h2000_0008;
    cyc();
    chk("busy_ready", hreadyout, 1);
    chk("busy_resp", hresp, 0);
    chk("busy_psel", psel, 0);
    do_xfer(32'h2000_0008, 3'd2, 1'b0, 32'h0, 0, 1'b0, 32'hA5A5_0003);

    // hready low: address phase must not be taken
    hsel = 1'b1; htrans = 2'b10; hready = 1'b0; hwrite = 1'b0; haddr = 32'h3000_0000;
    cyc();
    hready = 1'b1; htrans = 2'b00;
    cyc();
    chk("nohready_psel", psel, 0);

    // Reset in the middle of ACCESS
    wait_n = 100; err_n = 1'b0;
    hsel = 1'b1; htrans = 2'b10; haddr = 32'h4000_0010; hsize = 3'd2; hwrite = 1'b0;
    cyc();
    htrans = 2'b00;
    cyc(); cyc();
    chk("pre_rst_penable", penable, 1);
    rst = 1'b1;
    cyc();
    chk_reset_vals();
    rst = 1'b0; last_rd = '0;
    cyc();

    // Randomized traffic
    for (int i = 0; i < 60; i++) begin
      a = $urandom;
      if ($urandom_range(0, 1) == 1) a[1:0] = 2'b00;
      s  = ($urandom_range(0, 9) == 0) ? 3'($urandom_range(3, 7)) : 3'($urandom_range(0, 2));
      wn = ($urandom_range(0, 7) == 0) ? 16 : $urandom_range(0, 3);
      if ($urandom_range(0, 1) == 1) idle($urandom_range(1, 2));
      do_xfer(a, s, 1'($urandom_range(0, 1)), $urandom, wn,
              ($urandom_range(0, 5) == 0), $urandom);
    end
    idle(2);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
